// File: rtl/itype_pkg.sv
// Shared RV32I OP-IMM encoding constants and helpers.
// Also used by the I-type decoder.
package itype_pkg;

  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI      = 3'b000;
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_XORI      = 3'b100;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
  localparam logic [2:0] F3_ORI       = 3'b110;
  localparam logic [2:0] F3_ANDI      = 3'b111;

  localparam logic [6:0] F7_SRL = 7'b0000000;
  localparam logic [6:0] F7_SRA = 7'b0100000;

  typedef enum logic [2:0] {
    OP_ADDI,
    OP_SLLI,
    OP_XORI,
    OP_SRLI,
    OP_SRAI,
    OP_ORI,
    OP_ANDI
  } op_e;

  // Shifts only carry a 5-bit shamt; the upper immediate bits hold funct7.
  function automatic logic [31:0] encode_opimm(input op_e op, input logic [4:0] rs1,
                                               input logic [4:0] rd, input logic [11:0] imm);
    logic [31:0] word;
    word = {imm, rs1, F3_ADDI, rd, OPCODE_OPIMM};
    case (op)
      OP_ADDI: word = {imm, rs1, F3_ADDI, rd, OPCODE_OPIMM};
      OP_XORI: word = {imm, rs1, F3_XORI, rd, OPCODE_OPIMM};
      OP_ORI:  word = {imm, rs1, F3_ORI, rd, OPCODE_OPIMM};
      OP_ANDI: word = {imm, rs1, F3_ANDI, rd, OPCODE_OPIMM};
      OP_SLLI: word = {F7_SRL, imm[4:0], rs1, F3_SLLI, rd, OPCODE_OPIMM};
      OP_SRLI: word = {F7_SRL, imm[4:0], rs1, F3_SRLI_SRAI, rd, OPCODE_OPIMM};
      OP_SRAI: word = {F7_SRA, imm[4:0], rs1, F3_SRLI_SRAI, rd, OPCODE_OPIMM};
      default: word = {imm, rs1, F3_ADDI, rd, OPCODE_OPIMM};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/itype_fifo.sv
// Parameterised synchronous FIFO; the read port holds the last popped word
// while empty so downstream never sees stale storage contents.
module itype_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] last_word;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? last_word : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_word <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/itype_encoder.sv
// Encodes decoded ALU-immediate requests into RV32I OP-IMM words, buffers them
// for a downstream consumer and keeps saturating encode/error statistics.
module itype_encoder
  import itype_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             addi_en,
  input  logic             andi_en,
  input  logic             ori_en,
  input  logic             slli_en,
  input  logic             xori_en,
  input  logic             srli_en,
  input  logic             srai_en,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rd,
  input  logic [11:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instruction,
  output logic             err_illegal,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [6:0]  op_vec;
  logic        legal;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  op_e         op;
  logic [31:0] enc_word;

  assign op_vec    = {addi_en, andi_en, ori_en, slli_en, xori_en, srli_en, srai_en};
  assign legal     = $onehot(op_vec);
  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;

  // Priority order is irrelevant: op is only consumed when exactly one enable is set.
  always_comb begin
    op = OP_ADDI;
    if (andi_en)      op = OP_ANDI;
    else if (ori_en)  op = OP_ORI;
    else if (slli_en) op = OP_SLLI;
    else if (xori_en) op = OP_XORI;
    else if (srli_en) op = OP_SRLI;
    else if (srai_en) op = OP_SRAI;
  end

  assign enc_word = encode_opimm(op, rs1, rd, imm);

  itype_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && legal),
    .wdata (enc_word),
    .pop   (out_ready),
    .rdata (instruction),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Illegal requests still complete the handshake; they are only counted and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_illegal <= 1'b0;
      enc_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && legal && (enc_cnt != '1)) begin
        enc_cnt <= enc_cnt + CNT_W'(1);
      end
      if (accept && !legal && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_itype_encoder.sv
// Randomised self-checking bench for itype_encoder against a queue-based
// reference model that builds instruction words arithmetically.
module tb_itype_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       en_vec = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rd = '0;
  logic [11:0]      imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      instruction;
  logic             err_illegal;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  int check_count = 0;
  int error_count = 0;

  logic [31:0] m_queue[$];
  logic [31:0] m_last = '0;
  int          m_enc = 0;
  int          m_err = 0;
  bit          m_illegal = 0;

  always #5 clk = ~clk;

  // en_vec index: 0 addi, 1 andi, 2 ori, 3 slli, 4 xori, 5 srli, 6 srai
  itype_encoder #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .addi_en     (en_vec[0]),
    .andi_en     (en_vec[1]),
    .ori_en      (en_vec[2]),
    .slli_en     (en_vec[3]),
    .xori_en     (en_vec[4]),
    .srli_en     (en_vec[5]),
    .srai_en     (en_vec[6]),
    .rs1         (rs1),
    .rd          (rd),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .err_illegal (err_illegal),
    .enc_cnt     (enc_cnt),
    .err_cnt     (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int countEnables(input logic [6:0] en);
    int n = 0;
    for (int i = 0; i < 7; i++) n += en[i];
    return n;
  endfunction

  function automatic logic [31:0] refWord(input logic [6:0] en, input logic [4:0] r1,
                                          input logic [4:0] rdst, input logic [11:0] im);
    int idx = 0;
    int f3;
    longint field;
    int f3_tab[7] = '{0, 7, 6, 1, 4, 5, 5};
    for (int i = 0; i < 7; i++) if (en[i]) idx = i;
    f3 = f3_tab[idx];
    if (idx == 3 || idx == 5) field = im % 32;
    else if (idx == 6) field = 1024 + (im % 32);
    else field = im;
    return 32'(field * (1 << 20) + r1 * (1 << 15) + f3 * (1 << 12) + rdst * (1 << 7) + 19);
  endfunction

  function automatic int satInc(input int v);
    return (v == 255) ? 255 : v + 1;
  endfunction

  task automatic applyStimulus(input bit v, input logic [6:0] en, input logic [4:0] r1,
                               input logic [4:0] rdst, input logic [11:0] im, input bit ordy,
                               output bit accepted);
    bit pop_now;
    bit is_legal;
    logic [31:0] word;
    in_valid  = v;
    en_vec    = en;
    rs1       = r1;
    rd        = rdst;
    imm       = im;
    out_ready = ordy;
    checkOutput("pre_in_ready", 32'(in_ready), 32'(m_queue.size() < DEPTH));
    checkOutput("pre_out_valid", 32'(out_valid), 32'(m_queue.size() != 0));
    checkOutput("pre_instruction", instruction, (m_queue.size() != 0) ? m_queue[0] : m_last);
    accepted = v && (m_queue.size() < DEPTH);
    pop_now  = ordy && (m_queue.size() != 0);
    is_legal = (countEnables(en) == 1);
    word     = refWord(en, r1, rdst, im);
    @(posedge clk);
    #1;
    if (pop_now) m_last = m_queue.pop_front();
    m_illegal = accepted && !is_legal;
    if (accepted && is_legal) begin
      m_queue.push_back(word);
      m_enc = satInc(m_enc);
    end
    if (accepted && !is_legal) m_err = satInc(m_err);
    checkOutput("post_err_illegal", 32'(err_illegal), 32'(m_illegal));
    checkOutput("post_enc_cnt", 32'(enc_cnt), 32'(m_enc));
    checkOutput("post_err_cnt", 32'(err_cnt), 32'(m_err));
    checkOutput("post_out_valid", 32'(out_valid), 32'(m_queue.size() != 0));
  endtask

  task automatic modelReset();
    m_queue.delete();
    m_last    = '0;
    m_enc     = 0;
    m_err     = 0;
    m_illegal = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int tries;
    logic [6:0] en;
    $display("[TB] itype_encoder bench start");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instruction", instruction, 32'd0);
    checkOutput("rst_err_illegal", 32'(err_illegal), 32'd0);
    checkOutput("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    // Directed encoding vectors
    applyStimulus(1, 7'b0000001, 5'd7, 5'd9, 12'h304, 1, acc);
    checkOutput("vec_addi", instruction, 32'h30438493);
    checkOutput("vec_addi_cnt", 32'(enc_cnt), 32'd1);
    applyStimulus(1, 7'b1000000, 5'd5, 5'd13, 12'h003, 1, acc);
    checkOutput("vec_srai", instruction, 32'h4032D693);
    applyStimulus(1, 7'b0100000, 5'd5, 5'd13, 12'h003, 1, acc);
    checkOutput("vec_srli", instruction, 32'h0032D693);
    applyStimulus(1, 7'b0001000, 5'd1, 5'd1, 12'hFFF, 1, acc);
    checkOutput("vec_slli", instruction, 32'h01F09093);
    applyStimulus(1, 7'b0000010, 5'd31, 5'd0, 12'hFFF, 1, acc);
    checkOutput("vec_andi", instruction, 32'hFFFFF013);
    applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    checkOutput("hold_last", instruction, 32'hFFFFF013);

    // Backpressure: fill, stall the third request, then drain in order
    applyStimulus(1, 7'b0000001, 5'd1, 5'd2, 12'h011, 0, acc);
    applyStimulus(1, 7'b0010000, 5'd3, 5'd4, 12'h022, 0, acc);
    checkOutput("bp_full", 32'(in_ready), 32'd0);
    applyStimulus(1, 7'b0000100, 5'd5, 5'd6, 12'h033, 0, acc);
    checkOutput("bp_stall", 32'(acc), 32'd0);
    tries = 0;
    acc = 0;
    while (!acc && tries < 5) begin
      applyStimulus(1, 7'b0000100, 5'd5, 5'd6, 12'h033, 1, acc);
      tries++;
    end
    checkOutput("bp_accept", 32'(acc), 32'd1);
    repeat (3) applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);

    // Illegal requests and error counter saturation
    applyStimulus(1, 7'b0000000, 5'd1, 5'd1, 12'h001, 1, acc);
    applyStimulus(1, 7'b0000101, 5'd1, 5'd1, 12'h001, 1, acc);
    checkOutput("illegal_cnt", 32'(err_cnt), 32'd2);
    checkOutput("illegal_no_out", 32'(out_valid), 32'd0);
    repeat (260) applyStimulus(1, 7'b0000000, 5'd2, 5'd3, 12'h0AA, 1, acc);
    checkOutput("err_sat", 32'(err_cnt), 32'hFF);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) en = 7'($urandom);
      else en = 7'(1 << $urandom_range(0, 6));
      applyStimulus(1'($urandom_range(0, 3) != 0), en, 5'($urandom), 5'($urandom),
                    12'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end

    // Reset with a full FIFO
    applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);
    applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);
    applyStimulus(1, 7'b0000001, 5'd8, 5'd9, 12'h123, 0, acc);
    applyStimulus(1, 7'b0000010, 5'd10, 5'd11, 12'h456, 0, acc);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_instr", instruction, 32'd0);
    checkOutput("mid_rst_enc", 32'(enc_cnt), 32'd0);
    checkOutput("mid_rst_err", 32'(err_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (4) applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);
    applyStimulus(1, 7'b0010000, 5'd4, 5'd5, 12'h0F0, 1, acc);
    applyStimulus(0, 7'b0, 5'd0, 5'd0, 12'h0, 1, acc);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
